// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
// Access sizes, controller states and the byte count of each size.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the memory bytes at addr..addr+3 and the
// right-justified CPU data word, including sign/zero extension on reads.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [3:0][7:0] rbytes,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [3:0][7:0] wbytes,
  output logic [3:0]      wen
);

  logic [15:0] half;

  // rbytes[k] / wbytes[k] always correspond to mem[addr+k]
  always_comb begin
    rdata  = '0;
    wbytes = '0;
    wen    = '0;
    half   = '0;
    case (size)
      SZ_BYTE: begin
        rdata     = {{24{~uns & rbytes[0][7]}}, rbytes[0]};
        wbytes[0] = wdata[7:0];
        wen       = 4'b0001;
      end
      SZ_HALF: begin
        if (BIG_ENDIAN) begin
          half      = {rbytes[0], rbytes[1]};
          wbytes[0] = wdata[15:8];
          wbytes[1] = wdata[7:0];
        end else begin
          half      = {rbytes[1], rbytes[0]};
          wbytes[0] = wdata[7:0];
          wbytes[1] = wdata[15:8];
        end
        rdata = {{16{~uns & half[15]}}, half};
        wen   = 4'b0011;
      end
      SZ_WORD: begin
        if (BIG_ENDIAN) begin
          rdata  = {rbytes[0], rbytes[1],
                    rbytes[2], rbytes[3]};
          wbytes = {wdata[7:0], wdata[15:8],
                    wdata[23:16], wdata[31:24]};
        end else begin
          rdata  = {rbytes[3], rbytes[2],
                    rbytes[1], rbytes[0]};
          wbytes = wdata;
        end
        wen = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with sized access, error reporting,
// registered valid/ready response and a post-reset zeroing sweep.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES    = 128,
  parameter int ADDR_W         = 32,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH_BYTES);
  localparam state_t RST_STATE =
    CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [7:0] mem [0:DEPTH_BYTES-1];

  state_t          state, state_nx;
  logic [IW-1:0]   clr_ptr, clr_nx;
  logic [IW-1:0]   base;
  logic [ADDR_W:0] end_addr;
  logic            mis, range_err, err;
  logic            accept, wr_en;
  logic [3:0][7:0] rbytes, wbytes;
  logic [3:0]      wen;
  logic [31:0]     rdata;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= RST_STATE;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr_nx   = clr_ptr;
    case (state)
      S_CLEAR: begin
        clr_nx = clr_ptr + IW'(4);
        if (clr_ptr == IW'(DEPTH_BYTES - 4))
          state_nx = S_IDLE;
      end
      default: ;
    endcase
  end

  assign busy      = (state == S_CLEAR);
  assign req_ready = (state == S_IDLE) & Reset;
  assign accept    = req_valid & req_ready;

  // Range check is done one bit wider so high addresses never wrap
  assign end_addr = {1'b0, req_addr}
                  + {{(ADDR_W-2){1'b0}}, size_bytes(req_size)};
  assign range_err = end_addr > (ADDR_W+1)'(DEPTH_BYTES);

  always_comb begin
    mis = 1'b0;
    case (req_size)
      SZ_HALF: mis = req_addr[0];
      SZ_WORD: mis = |req_addr[1:0];
      SZ_BAD:  mis = 1'b1;
      default: ;
    endcase
  end

  assign err   = mis | range_err;
  assign wr_en = accept & req_write & ~err;
  assign base  = req_addr[IW-1:0];

  always_comb begin
    for (int k = 0; k < 4; k++)
      rbytes[k] = mem[base + IW'(k)];
  end

  dmem_lane_align #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .size   (req_size),
    .uns    (req_unsigned),
    .rbytes (rbytes),
    .wdata  (req_wdata),
    .rdata  (rdata),
    .wbytes (wbytes),
    .wen    (wen)
  );

  always_ff @(posedge CLK) begin
    if (state == S_CLEAR) begin
      for (int k = 0; k < 4; k++)
        mem[clr_ptr + IW'(k)] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++)
        if (wen[k])
          mem[base + IW'(k)] <= wbytes[k];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & err;
      rsp_rdata <= (accept & ~req_write & ~err)
                 ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed scoreboard bench for data_memory_ctrl (128 bytes).
// Expected responses are queued at acceptance and checked next cycle.
module tb_data_memory_ctrl;

  localparam bit BE = 1'b1;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int nbusy;
  bit rdy_bad;

  data_memory_ctrl #(
    .DEPTH_BYTES    (128),
    .ADDR_W         (32),
    .BIG_ENDIAN     (BE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, ".valid"}, 32'(rsp_valid), 32'd1);
      chk({x.tag, ".rdata"}, rsp_rdata, x.d);
      chk({x.tag, ".err"}, 32'(rsp_err), 32'(x.e));
    end else if (rsp_valid !== 1'b0) begin
      chk("spurious_valid", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic send(string tag, logic w, logic [1:0] sz,
                      logic u, logic [31:0] a,
                      logic [31:0] wd, logic [31:0] ed,
                      logic ee);
    exp_t x;
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    @(negedge CLK);
    check_rsp();
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge CLK);
    x.d = ed;
    x.e = ee;
    x.tag = tag;
    sb.push_back(x);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge CLK);
    check_rsp();
    @(posedge CLK);
    #1;
  endtask

  task automatic count_busy(output int n, output bit bad);
    n = 0;
    bad = 1'b0;
    @(negedge CLK);
    while (busy === 1'b1 && n < 100) begin
      if (req_ready !== 1'b0) bad = 1'b1;
      n++;
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_vals(string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rvalid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rerr"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    reset_vals("rst");
    @(posedge CLK);
    #1 Reset = 1'b1;
    count_busy(nbusy, rdy_bad);
    chk("sweep_len", 32'(nbusy), 32'd32);
    chk("sweep_noready", 32'(rdy_bad), 32'd0);

    send("rd7c", 0, 2'b10, 0, 32'h7C, 0, 32'h0, 0);

    send("wr10", 1, 2'b10, 0, 32'h10, 32'h12345678, 0, 0);
    send("rd10", 0, 2'b10, 0, 32'h10, 0, 32'h12345678, 0);
    send("rb10", 0, 2'b00, 1, 32'h10, 0,
         BE ? 32'h12 : 32'h78, 0);

    send("wb21", 1, 2'b00, 0, 32'h21, 32'h80, 0, 0);
    send("rb21s", 0, 2'b00, 0, 32'h21, 0, 32'hFFFFFF80, 0);
    send("rb21u", 0, 2'b00, 1, 32'h21, 0, 32'h00000080, 0);
    send("wh22", 1, 2'b01, 0, 32'h22, 32'hBEEF, 0, 0);
    send("rh22s", 0, 2'b01, 0, 32'h22, 0, 32'hFFFFBEEF, 0);
    send("rh22u", 0, 2'b01, 1, 32'h22, 0, 32'h0000BEEF, 0);
    send("rw20", 0, 2'b10, 0, 32'h20, 0,
         BE ? 32'h0080BEEF : 32'hBEEF8000, 0);

    send("w00", 1, 2'b10, 0, 32'h00, 32'h11223344, 0, 0);
    send("rw06", 0, 2'b10, 0, 32'h06, 0, 0, 1);
    send("wh03", 1, 2'b01, 0, 32'h03, 32'hFFFF, 0, 1);
    send("sz11", 1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 0, 1);
    send("rsz11", 0, 2'b11, 0, 32'h00, 0, 0, 1);
    send("chk00", 0, 2'b10, 0, 32'h00, 0, 32'h11223344, 0);
    send("chk04", 0, 2'b10, 0, 32'h04, 0, 32'h0, 0);

    send("w7c", 1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 0, 0);
    send("r7c", 0, 2'b10, 0, 32'h7C, 0, 32'hCAFEF00D, 0);
    send("rb7f", 0, 2'b00, 0, 32'h7F, 0,
         BE ? 32'h0000000D : 32'hFFFFFFCA, 0);
    send("w80", 1, 2'b10, 0, 32'h80, 32'h55555555, 0, 1);
    send("wh7f", 1, 2'b01, 0, 32'h7F, 32'h5555, 0, 1);
    send("r80", 0, 2'b10, 0, 32'h80, 0, 0, 1);
    send("rbff", 0, 2'b00, 0, 32'hFFFFFFFF, 0, 0, 1);
    send("nowrap", 0, 2'b10, 0, 32'h00, 0, 32'h11223344, 0);

    send("b2b_w0", 1, 2'b10, 0, 32'h00, 32'hDEADBEEF, 0, 0);
    send("b2b_r0", 0, 2'b10, 0, 32'h00, 0, 32'hDEADBEEF, 0);
    send("b2b_r4", 0, 2'b10, 0, 32'h04, 0, 32'h0, 0);
    idle();

    send("midrst", 0, 2'b10, 0, 32'h00, 0, 32'hDEADBEEF, 0);
    void'(sb.pop_front());
    req_valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("midrst.rvalid", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    reset_vals("rst2");
    @(posedge CLK);
    #1 Reset = 1'b1;
    count_busy(nbusy, rdy_bad);
    chk("sweep2_len", 32'(nbusy), 32'd32);

    @(posedge CLK);
    #1 Reset = 1'b1;
    Reset = 1'b0;
    @(negedge CLK);
    reset_vals("rst3");
    @(posedge CLK);
    #1 Reset = 1'b1;
    repeat (10) @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    reset_vals("rst4");
    @(posedge CLK);
    #1 Reset = 1'b1;
    count_busy(nbusy, rdy_bad);
    chk("sweep_restart_len", 32'(nbusy), 32'd32);
    chk("sweep_restart_noready", 32'(rdy_bad), 32'd0);

    send("cleared0", 0, 2'b10, 0, 32'h00, 0, 32'h0, 0);
    send("cleared7c", 0, 2'b10, 0, 32'h7C, 0, 32'h0, 0);
    idle();
    idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
